// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard control unit.
//   hz_state_e : FSM encoding (IDLE=0, LU_STALL=1, MC_BUSY=2, FLUSH=3)
//   FWD_RF     : forward-select value meaning "read the register file"
//   sel_width  : width needed to encode 0..n forward selects
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MC_BUSY  = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_e;

  localparam int FWD_RF = 0;

  function automatic int sel_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_match.sv
// fwd_match: combinational priority matcher for one consumer operand.
// Ports:
//   rs, rs_used             : consumer source register and its use flag
//   src_rd, src_wr          : destination/write-enable of each source stage
//   src_is_load             : source stage result still comes from memory
//   sel                     : FWD_RF, or lowest matching stage index + 1
//   load_hit                : the selected source is a load
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = sel_width(NUM_FWD)
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic                      rs_used,
  input  logic [NUM_FWD*REG_AW-1:0] src_rd,
  input  logic [NUM_FWD-1:0]        src_wr,
  input  logic [NUM_FWD-1:0]        src_is_load,
  output logic [SEL_W-1:0]          sel,
  output logic                      load_hit
);

  // Scan oldest to youngest so the youngest (lowest index) match is the
  // last one written and therefore wins.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_hit = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (rs_used && (rs != '0) && src_wr[i] &&
          (src_rd[i*REG_AW +: REG_AW] == rs)) begin
        sel      = SEL_W'(i + 1);
        load_hit = src_is_load[i];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: operand forwarding, load-use / multi-cycle stall and
// branch flush sequencing for the decode/execute boundary.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rs1/rs2, rs*_used     : consumer operands and use flags
//   src_rd/src_wr         : per-stage destination register / write enable
//   src_is_load           : per-stage result not yet available (load)
//   br_taken              : branch resolved taken this cycle
//   mc_start / mc_done    : multi-cycle op issue / completion
//   fwd_sel1 / fwd_sel2   : 0 = register file, k = source stage k-1
//   stall / flush         : pipeline hold / squash
//   busy_state            : current FSM state (debug)
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int NUM_FWD     = 2,
  parameter int LU_STALL    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = sel_width(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [NUM_FWD*REG_AW-1:0] src_rd,
  input  logic [NUM_FWD-1:0]        src_wr,
  input  logic [NUM_FWD-1:0]        src_is_load,
  input  logic                      br_taken,
  input  logic                      mc_start,
  input  logic                      mc_done,
  output logic [SEL_W-1:0]          fwd_sel1,
  output logic [SEL_W-1:0]          fwd_sel2,
  output logic                      stall,
  output logic                      flush,
  output logic [1:0]                busy_state
);

  localparam int CNT_MAX = (LU_STALL > FLUSH_DEPTH) ? LU_STALL : FLUSH_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_DEPTH - 1);

  // Counters hold at zero rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic [SEL_W-1:0] sel1_raw, sel2_raw;
  logic             lh1, lh2, lu_hit;

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_br, pend_br_nxt;
  logic             stall_c, flush_c;

  fwd_match #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match1 (
    .rs          (rs1),
    .rs_used     (rs1_used),
    .src_rd      (src_rd),
    .src_wr      (src_wr),
    .src_is_load (src_is_load),
    .sel         (sel1_raw),
    .load_hit    (lh1)
  );

  fwd_match #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match2 (
    .rs          (rs2),
    .rs_used     (rs2_used),
    .src_rd      (src_rd),
    .src_wr      (src_wr),
    .src_is_load (src_is_load),
    .sel         (sel2_raw),
    .load_hit    (lh2)
  );

  assign lu_hit = lh1 | lh2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HZ_IDLE;
      cnt     <= '0;
      pend_br <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_br <= pend_br_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_br_nxt = pend_br;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    case (state)
      HZ_IDLE: begin
        if (br_taken) begin
          flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt = HZ_FLUSH;
            cnt_nxt   = FL_RELOAD;
          end
        end else if (mc_start) begin
          // mc_done in the issue cycle is deliberately not looked at.
          stall_c   = 1'b1;
          state_nxt = HZ_MC_BUSY;
        end else if (lu_hit) begin
          stall_c = 1'b1;
          if (LU_STALL > 1) begin
            state_nxt = HZ_LU_STALL;
            cnt_nxt   = LU_RELOAD;
          end
        end
      end
      HZ_LU_STALL: begin
        if (br_taken) begin
          // A taken branch squashes the stalled consumer anyway.
          flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt = HZ_FLUSH;
            cnt_nxt   = FL_RELOAD;
          end else begin
            state_nxt = HZ_IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt_dec(cnt);
          if (cnt <= CNT_W'(1)) state_nxt = HZ_IDLE;
        end
      end
      HZ_MC_BUSY: begin
        if (mc_done) begin
          pend_br_nxt = 1'b0;
          if (pend_br || br_taken) begin
            flush_c = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_nxt = HZ_FLUSH;
              cnt_nxt   = FL_RELOAD;
            end else begin
              state_nxt = HZ_IDLE;
            end
          end else begin
            state_nxt = HZ_IDLE;
          end
        end else begin
          // Branch resolved behind the busy unit: remember it, flush later.
          stall_c = 1'b1;
          if (br_taken) pend_br_nxt = 1'b1;
        end
      end
      HZ_FLUSH: begin
        flush_c = 1'b1;
        if (br_taken) begin
          cnt_nxt = FL_RELOAD;
        end else begin
          cnt_nxt = cnt_dec(cnt);
          if (cnt <= CNT_W'(1)) state_nxt = HZ_IDLE;
        end
      end
      default: state_nxt = HZ_IDLE;
    endcase
  end

  assign stall      = ~rst & stall_c;
  assign flush      = ~rst & flush_c;
  // A stalled consumer must not see a load's not-yet-valid data.
  assign fwd_sel1   = (rst || (stall_c && lh1)) ? SEL_W'(FWD_RF) : sel1_raw;
  assign fwd_sel2   = (rst || (stall_c && lh2)) ? SEL_W'(FWD_RF) : sel2_raw;
  assign busy_state = state;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic [9:0] src_rd;
  logic [1:0] src_wr, src_is_load;
  logic       br_taken, mc_start, mc_done;

  // u_a: LU_STALL=2, FLUSH_DEPTH=2 ; u_b: LU_STALL=1, FLUSH_DEPTH=3
  logic [1:0] a_sel1, a_sel2, a_state, b_sel1, b_sel2, b_state;
  logic       a_stall, a_flush, b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .NUM_FWD(2), .LU_STALL(2), .FLUSH_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .src_rd(src_rd), .src_wr(src_wr), .src_is_load(src_is_load), .br_taken(br_taken),
    .mc_start(mc_start), .mc_done(mc_done), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2),
    .stall(a_stall), .flush(a_flush), .busy_state(a_state)
  );

  hazard_ctrl_unit #(.REG_AW(5), .NUM_FWD(2), .LU_STALL(1), .FLUSH_DEPTH(3)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .src_rd(src_rd), .src_wr(src_wr), .src_is_load(src_is_load), .br_taken(br_taken),
    .mc_start(mc_start), .mc_done(mc_done), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
    .stall(b_stall), .flush(b_flush), .busy_state(b_state)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [9:0] rd;      // {stage1 rd, stage0 rd}
    logic [1:0] wr, ld;
    logic [1:0] e1, e2;
    logic       est;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic clr_in();
    rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    src_rd = '0; src_wr = '0; src_is_load = '0;
    br_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  // Move to the next cycle: inputs are driven shortly after the edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample outputs mid-cycle, away from the active edge.
  task automatic sample();
    @(negedge clk);
  endtask

  logic [7:0] mc_stall_exp, mc_flush_exp;
  logic [4:0] fl_b_exp, fl_a_exp;

  initial begin
    tbl[0] = '{5'd5,  5'd0,  1'b1, 1'b0, {5'd5, 5'd5},  2'b11, 2'b00, 2'd1, 2'd0, 1'b0};
    tbl[1] = '{5'd5,  5'd0,  1'b1, 1'b0, {5'd5, 5'd5},  2'b10, 2'b00, 2'd2, 2'd0, 1'b0};
    tbl[2] = '{5'd1,  5'd0,  1'b0, 1'b1, {5'd9, 5'd0},  2'b01, 2'b00, 2'd0, 2'd0, 1'b0};
    tbl[3] = '{5'd7,  5'd0,  1'b0, 1'b0, {5'd7, 5'd7},  2'b11, 2'b00, 2'd0, 2'd0, 1'b0};
    tbl[4] = '{5'd3,  5'd4,  1'b1, 1'b1, {5'd3, 5'd4},  2'b11, 2'b00, 2'd2, 2'd1, 1'b0};
    tbl[5] = '{5'd6,  5'd6,  1'b1, 1'b1, {5'd6, 5'd6},  2'b00, 2'b00, 2'd0, 2'd0, 1'b0};
    tbl[6] = '{5'd8,  5'd0,  1'b1, 1'b0, {5'd8, 5'd8},  2'b11, 2'b10, 2'd1, 2'd0, 1'b0};
    tbl[7] = '{5'd31, 5'd31, 1'b1, 1'b1, {5'd31, 5'd2}, 2'b11, 2'b00, 2'd2, 2'd2, 1'b0};
    tbl[8] = '{5'd9,  5'd0,  1'b0, 1'b0, {5'd0, 5'd9},  2'b01, 2'b01, 2'd0, 2'd0, 1'b0};

    // Reset with every hazard input active: outputs must stay quiet.
    clr_in();
    rst = 1'b1;
    rs1 = 5'd5; rs1_used = 1'b1; src_rd = {5'd5, 5'd5}; src_wr = 2'b11;
    src_is_load = 2'b01; br_taken = 1'b1; mc_start = 1'b1;
    next_cyc();
    sample();
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_flush", {31'd0, a_flush}, 32'd0);
    chk("rst_sel1",  {30'd0, a_sel1},  32'd0);
    chk("rst_state", {30'd0, a_state}, 32'd0);
    next_cyc();
    rst = 1'b0;
    clr_in();
    sample();
    chk("post_rst_state", {30'd0, a_state}, 32'd0);
    chk("post_rst_stall", {31'd0, a_stall}, 32'd0);

    // Forwarding table (no stall-causing vectors, FSM stays IDLE).
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      clr_in();
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rs1_used = tbl[i].u1; rs2_used = tbl[i].u2;
      src_rd = tbl[i].rd; src_wr = tbl[i].wr; src_is_load = tbl[i].ld;
      sample();
      chk($sformatf("vec%0d_sel1", i),  {30'd0, a_sel1},  {30'd0, tbl[i].e1});
      chk($sformatf("vec%0d_sel2", i),  {30'd0, a_sel2},  {30'd0, tbl[i].e2});
      chk($sformatf("vec%0d_stall", i), {31'd0, a_stall}, {31'd0, tbl[i].est});
    end

    // Load-use on rs1 from stage 0, LU_STALL=2.
    next_cyc();
    clr_in();
    rs1 = 5'd3; rs1_used = 1'b1; src_rd = {5'd0, 5'd3}; src_wr = 2'b01; src_is_load = 2'b01;
    sample();
    chk("lu_c0_stall", {31'd0, a_stall}, 32'd1);
    chk("lu_c0_sel1",  {30'd0, a_sel1},  32'd0);
    next_cyc();
    sample();
    chk("lu_c1_stall", {31'd0, a_stall}, 32'd1);
    chk("lu_c1_state", {30'd0, a_state}, 32'd1);
    chk("lu_c1_sel1",  {30'd0, a_sel1},  32'd0);
    next_cyc();
    src_is_load = 2'b00;
    sample();
    chk("lu_c2_stall", {31'd0, a_stall}, 32'd0);
    chk("lu_c2_state", {30'd0, a_state}, 32'd0);
    chk("lu_c2_sel1",  {30'd0, a_sel1},  32'd1);

    // Branch arriving during a load-use stall cancels it and flushes.
    next_cyc();
    src_is_load = 2'b01;
    sample();
    chk("lubr_c0_stall", {31'd0, a_stall}, 32'd1);
    next_cyc();
    br_taken = 1'b1;
    sample();
    chk("lubr_c1_stall", {31'd0, a_stall}, 32'd0);
    chk("lubr_c1_flush", {31'd0, a_flush}, 32'd1);
    next_cyc();
    clr_in();
    sample();
    chk("lubr_c2_state", {30'd0, a_state}, 32'd3);
    chk("lubr_c2_flush", {31'd0, a_flush}, 32'd1);
    next_cyc();
    sample();
    chk("lubr_c3_flush", {31'd0, a_flush}, 32'd0);
    chk("lubr_c3_state", {30'd0, a_state}, 32'd0);

    // Multi-cycle op with a branch buried behind it (FLUSH_DEPTH=2).
    mc_stall_exp = 8'b0001_1111;  // bit n = cycle n
    mc_flush_exp = 8'b0110_0000;
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      clr_in();
      mc_start = (c == 0);
      br_taken = (c == 2);
      mc_done  = (c == 5);
      sample();
      chk($sformatf("mc_c%0d_stall", c), {31'd0, a_stall}, {31'd0, mc_stall_exp[c]});
      chk($sformatf("mc_c%0d_flush", c), {31'd0, a_flush}, {31'd0, mc_flush_exp[c]});
    end

    // Back-to-back branches: u_b (depth 3) and u_a (depth 2).
    fl_b_exp = 5'b01111;
    fl_a_exp = 5'b00111;
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      clr_in();
      br_taken = (c < 2);
      sample();
      chk($sformatf("flb_c%0d", c), {31'd0, b_flush}, {31'd0, fl_b_exp[c]});
      chk($sformatf("fla_c%0d", c), {31'd0, a_flush}, {31'd0, fl_a_exp[c]});
      chk($sformatf("flb_c%0d_stall", c), {31'd0, b_stall}, 32'd0);
    end
    chk("flb_end_state", {30'd0, b_state}, 32'd0);

    // Reset while busy with a pending branch.
    next_cyc();
    clr_in();
    mc_start = 1'b1;
    sample();
    chk("rb_c0_stall", {31'd0, a_stall}, 32'd1);
    next_cyc();
    clr_in();
    br_taken = 1'b1;
    sample();
    chk("rb_c1_flush", {31'd0, a_flush}, 32'd0);
    next_cyc();
    clr_in();
    rst = 1'b1;
    sample();
    chk("rb_c2_stall", {31'd0, a_stall}, 32'd0);
    chk("rb_c2_flush", {31'd0, a_flush}, 32'd0);
    next_cyc();
    rst = 1'b0;
    sample();
    chk("rb_c3_state", {30'd0, a_state}, 32'd0);
    chk("rb_c3_stall", {31'd0, a_stall}, 32'd0);
    chk("rb_c3_flush", {31'd0, a_flush}, 32'd0);
    next_cyc();
    mc_done = 1'b1;
    sample();
    chk("rb_c4_flush", {31'd0, a_flush}, 32'd0);
    chk("rb_c4_stall", {31'd0, a_stall}, 32'd0);
    next_cyc();
    clr_in();
    sample();
    chk("rb_c5_flush", {31'd0, a_flush}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
